// File: rtl/bram_debug_sequencer_pkg.sv
// Shared definitions for the BRAM load/run/dump sequencer.
//   seq_state_e : top-level session states
//   WE_ALL      : full-word byte enable
//   WORD_SHIFT  : word index -> byte address shift
package bram_debug_sequencer_pkg;
  typedef enum logic [2:0] {
    IDLE, LOAD_D, LOAD_I, RST, RUN, DUMP_D, DUMP_I
  } seq_state_e;

  localparam logic [3:0] WE_ALL     = 4'b1111;
  localparam int         WORD_SHIFT = 2;

  function automatic logic [31:0] byte_addr(input logic [31:0] word_idx);
    return word_idx << WORD_SHIFT;
  endfunction
endpackage

// File: rtl/bram_debug_sequencer_if.sv
// Host link stream between the sequencer and a UART/JTAG bridge.
//   in_*  : host -> sequencer load words (valid/ready, last per segment)
//   out_* : sequencer -> host dump words (valid/ready, last per image)
// master = host bridge side, slave = sequencer side.
interface bram_debug_sequencer_if;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_last;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_last;
  logic        out_ready;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/bram_dump_reader.sv
// Streams one BRAM image out over a valid/ready handshake.
//   en_i        : high while a dump state is active; low clears the walker
//   rd_data_i   : RAM read data (already muxed to the active RAM)
//   out_ready_i : host accepts the held word
//   idx_o       : word index currently presented to the RAM
//   out_*_o     : held dump word, valid and last-of-image flag
//   done_o      : the last word of the image is being accepted this cycle
module bram_dump_reader #(
  parameter int BRAM_WORDS = 4096,
  parameter int RD_LAT     = 2,
  parameter int AW         = $clog2(BRAM_WORDS) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en_i,
  input  logic [31:0]   rd_data_i,
  input  logic          out_ready_i,
  output logic [AW-1:0] idx_o,
  output logic          out_valid_o,
  output logic [31:0]   out_data_o,
  output logic          out_last_o,
  output logic          done_o
);
  localparam int LW = $clog2(RD_LAT + 1);

  logic [AW-1:0] idx_q;
  logic [LW-1:0] lat_q;
  logic          vld_q, last_q;
  logic [31:0]   data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      lat_q  <= '0;
      vld_q  <= 1'b0;
      last_q <= 1'b0;
      data_q <= '0;
    end else if (!en_i) begin
      idx_q  <= '0;
      lat_q  <= '0;
      vld_q  <= 1'b0;
      last_q <= 1'b0;
    end else if (vld_q) begin
      // Word held until accepted; the index wraps after the last word so
      // the next image starts at 0 without a separate clear.
      if (out_ready_i) begin
        vld_q  <= 1'b0;
        last_q <= 1'b0;
        idx_q  <= last_q ? '0 : idx_q + 1'b1;
      end
    end else if (lat_q == LW'(RD_LAT - 1)) begin
      // Address has been stable for RD_LAT cycles: read data is good now.
      lat_q  <= '0;
      vld_q  <= 1'b1;
      data_q <= rd_data_i;
      last_q <= (idx_q == AW'(BRAM_WORDS - 1));
    end else begin
      lat_q <= lat_q + 1'b1;
    end
  end

  assign idx_o       = idx_q;
  assign out_valid_o = vld_q;
  assign out_data_o  = data_q;
  assign out_last_o  = last_q;
  assign done_o      = en_i & vld_q & out_ready_i & last_q;
endmodule

// File: rtl/bram_debug_sequencer.sv
// Load/run/dump sequencer around the RV32Core debug ports.
//   CPU_CLK, CPU_RST_N : clock, async active-low reset
//   start              : session start pulse (IDLE only)
//   host               : host link stream (load in, dump out)
//   busy, overflow     : status; overflow is sticky until the next start
//   core_rst           : core reset, low only while the program runs
//   dram_*/iram_*      : debug port 2 of the Data / Inst RAMs
module bram_debug_sequencer
  import bram_debug_sequencer_pkg::*;
#(
  parameter int BRAM_WORDS = 4096,
  parameter int RST_CYCLES = 5,
  parameter int RUN_CYCLES = 200000,
  parameter int RD_LAT     = 2
) (
  input  logic                  CPU_CLK,
  input  logic                  CPU_RST_N,
  input  logic                  start,
  bram_debug_sequencer_if.slave host,
  output logic                  busy,
  output logic                  overflow,
  output logic                  core_rst,
  output logic [31:0]           dram_a2,
  output logic [31:0]           dram_wd2,
  output logic [3:0]            dram_we2,
  input  logic [31:0]           dram_rd2,
  output logic [31:0]           iram_a2,
  output logic [31:0]           iram_wd2,
  output logic [3:0]            iram_we2,
  input  logic [31:0]           iram_rd2
);
  localparam int AW = $clog2(BRAM_WORDS) + 1;
  localparam int CW = $clog2(RST_CYCLES + RUN_CYCLES + 1);

  seq_state_e    state_q;
  logic [AW-1:0] idx_q;
  logic [CW-1:0] cnt_q;
  logic          overflow_q, core_rst_q;
  logic [31:0]   dram_a2_q, dram_wd2_q, iram_a2_q, iram_wd2_q;
  logic [3:0]    dram_we2_q, iram_we2_q;

  logic          in_ready, xfer, idx_max, seg_end;
  logic          rd_en, rd_done;
  logic [AW-1:0] rd_idx;
  logic [31:0]   rd_data;

  assign in_ready = (state_q == LOAD_D) || (state_q == LOAD_I);
  assign xfer     = host.in_valid && in_ready;
  assign idx_max  = (idx_q == AW'(BRAM_WORDS - 1));
  assign seg_end  = xfer && (host.in_last || idx_max);

  always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
    if (!CPU_RST_N) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
      core_rst_q <= 1'b1;
      dram_a2_q  <= '0;
      dram_wd2_q <= '0;
      dram_we2_q <= '0;
      iram_a2_q  <= '0;
      iram_wd2_q <= '0;
      iram_we2_q <= '0;
    end else begin
      // Byte enables are single-cycle strobes.
      dram_we2_q <= '0;
      iram_we2_q <= '0;
      case (state_q)
        IDLE: if (start) begin
          overflow_q <= 1'b0;
          idx_q      <= '0;
          state_q    <= LOAD_D;
        end
        LOAD_D, LOAD_I: if (xfer) begin
          if (state_q == LOAD_D) begin
            dram_a2_q  <= byte_addr(32'(idx_q));
            dram_wd2_q <= host.in_data;
            dram_we2_q <= WE_ALL;
          end else begin
            iram_a2_q  <= byte_addr(32'(idx_q));
            iram_wd2_q <= host.in_data;
            iram_we2_q <= WE_ALL;
          end
          if (seg_end) begin
            idx_q <= '0;
            // A full segment without in_last: the host sent too much.
            if (idx_max && !host.in_last) overflow_q <= 1'b1;
            state_q <= (state_q == LOAD_D) ? LOAD_I : RST;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        RST: if (cnt_q == CW'(RST_CYCLES - 1)) begin
          cnt_q      <= '0;
          core_rst_q <= 1'b0;
          state_q    <= RUN;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
        RUN: if (cnt_q == CW'(RUN_CYCLES - 1)) begin
          cnt_q      <= '0;
          core_rst_q <= 1'b1;
          state_q    <= DUMP_D;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
        DUMP_D: if (rd_done) state_q <= DUMP_I;
        DUMP_I: if (rd_done) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // One reader serves both images; the active RAM is selected by state.
  assign rd_en   = (state_q == DUMP_D) || (state_q == DUMP_I);
  assign rd_data = (state_q == DUMP_I) ? iram_rd2 : dram_rd2;

  bram_dump_reader #(
    .BRAM_WORDS(BRAM_WORDS),
    .RD_LAT    (RD_LAT),
    .AW        (AW)
  ) u_reader (
    .clk        (CPU_CLK),
    .rst_n      (CPU_RST_N),
    .en_i       (rd_en),
    .rd_data_i  (rd_data),
    .out_ready_i(host.out_ready),
    .idx_o      (rd_idx),
    .out_valid_o(host.out_valid),
    .out_data_o (host.out_data),
    .out_last_o (host.out_last),
    .done_o     (rd_done)
  );

  assign host.in_ready = in_ready;
  assign busy          = (state_q != IDLE);
  assign overflow      = overflow_q;
  // Registered so the core reset never sees a state-decode glitch.
  assign core_rst      = core_rst_q;

  assign dram_a2  = (state_q == DUMP_D) ? byte_addr(32'(rd_idx)) : dram_a2_q;
  assign dram_wd2 = dram_wd2_q;
  assign dram_we2 = dram_we2_q;
  assign iram_a2  = (state_q == DUMP_I) ? byte_addr(32'(rd_idx)) : iram_a2_q;
  assign iram_wd2 = iram_wd2_q;
  assign iram_we2 = iram_we2_q;
endmodule

// File: tb/tb_bram_debug_sequencer.sv
// Directed bench for bram_debug_sequencer with a small BRAM model.
module tb_bram_debug_sequencer;
  localparam int W    = 8;
  localparam int RSTC = 2;
  localparam int RUNC = 20;
  localparam int RDL  = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        busy, overflow, core_rst;
  logic [31:0] dram_a2, dram_wd2, dram_rd2, iram_a2, iram_wd2, iram_rd2;
  logic [3:0]  dram_we2, iram_we2;

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] dmem [W] = '{default: 32'h0};
  logic [31:0] imem [W] = '{default: 32'h0};
  logic [31:0] exp_d [W] = '{default: 32'h0};
  logic [31:0] exp_i [W] = '{default: 32'h0};

  always #5 clk = ~clk;

  bram_debug_sequencer_if hif();

  bram_debug_sequencer #(
    .BRAM_WORDS(W), .RST_CYCLES(RSTC), .RUN_CYCLES(RUNC), .RD_LAT(RDL)
  ) dut (
    .CPU_CLK(clk), .CPU_RST_N(rst_n), .start(start), .host(hif.slave),
    .busy(busy), .overflow(overflow), .core_rst(core_rst),
    .dram_a2(dram_a2), .dram_wd2(dram_wd2), .dram_we2(dram_we2), .dram_rd2(dram_rd2),
    .iram_a2(iram_a2), .iram_wd2(iram_wd2), .iram_we2(iram_we2), .iram_rd2(iram_rd2)
  );

  // BRAM model: write on the edge after we2 is seen, registered read, so a
  // new address gives usable data RD_LAT edges after it appears.
  always @(posedge clk) begin
    if (dram_we2 == 4'hf) dmem[dram_a2[4:2]] <= dram_wd2;
    if (iram_we2 == 4'hf) imem[iram_a2[4:2]] <= iram_wd2;
    dram_rd2 <= dmem[dram_a2[4:2]];
    iram_rd2 <= imem[iram_a2[4:2]];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_chk++; if (core_rst !== 1'b1) begin n_fail++; $display("FAIL reset_core_rst got %b exp 1", core_rst); end
    n_chk++; if (hif.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %b exp 0", hif.in_ready); end
    n_chk++; if (hif.out_valid !== 1'b0 || hif.out_last !== 1'b0) begin n_fail++; $display("FAIL reset_out got v=%b l=%b exp 0 0", hif.out_valid, hif.out_last); end
    n_chk++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got %b exp 0", overflow); end
    n_chk++; if (dram_a2 !== 32'h0 || iram_a2 !== 32'h0 || dram_we2 !== 4'h0 || iram_we2 !== 4'h0) begin
      n_fail++; $display("FAIL reset_ram_ports got da=%h ia=%h dwe=%h iwe=%h exp 0", dram_a2, iram_a2, dram_we2, iram_we2); end
    rst_n = 1'b1;
    tick();
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy got %b exp 0", busy); end
  endtask

  task automatic test_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    n_chk++; if (busy !== 1'b1 || hif.in_ready !== 1'b1) begin n_fail++; $display("FAIL start got busy=%b rdy=%b exp 1 1", busy, hif.in_ready); end
    n_chk++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL start_overflow got %b exp 0", overflow); end
  endtask

  // Presents one word (inputs stay asserted so callers can go back to back).
  task automatic load_word(input logic [31:0] d, input logic last, input bit inst, input int idx);
    hif.in_valid = 1'b1; hif.in_data = d; hif.in_last = last;
    n_chk++; if (hif.in_ready !== 1'b1) begin n_fail++; $display("FAIL load_ready w%0d got %b exp 1", idx, hif.in_ready); end
    tick();
    if (inst) begin
      exp_i[idx] = d;
      n_chk++; if (iram_we2 !== 4'hf || dram_we2 !== 4'h0) begin n_fail++; $display("FAIL load_we_i w%0d got i=%h d=%h exp f 0", idx, iram_we2, dram_we2); end
      n_chk++; if (iram_a2 !== 32'(idx * 4) || iram_wd2 !== d) begin n_fail++; $display("FAIL load_wr_i got a=%h wd=%h exp %h %h", iram_a2, iram_wd2, idx * 4, d); end
    end else begin
      exp_d[idx] = d;
      n_chk++; if (dram_we2 !== 4'hf || iram_we2 !== 4'h0) begin n_fail++; $display("FAIL load_we_d w%0d got d=%h i=%h exp f 0", idx, dram_we2, iram_we2); end
      n_chk++; if (dram_a2 !== 32'(idx * 4) || dram_wd2 !== d) begin n_fail++; $display("FAIL load_wr_d got a=%h wd=%h exp %h %h", dram_a2, dram_wd2, idx * 4, d); end
    end
    n_chk++; if (core_rst !== 1'b1) begin n_fail++; $display("FAIL load_core_rst got %b exp 1", core_rst); end
  endtask

  task automatic test_basic_load();
    test_start();
    load_word(32'h11, 1'b0, 1'b0, 0);
    load_word(32'h22, 1'b0, 1'b0, 1);
    load_word(32'h33, 1'b1, 1'b0, 2);
    load_word(32'hA0, 1'b0, 1'b1, 0);
    load_word(32'hA1, 1'b1, 1'b1, 1);
    hif.in_valid = 1'b0; hif.in_last = 1'b0;
    n_chk++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL basic_overflow got %b exp 0", overflow); end
    n_chk++; if (hif.in_ready !== 1'b0) begin n_fail++; $display("FAIL basic_done_ready got %b exp 0", hif.in_ready); end
  endtask

  task automatic test_overflow();
    test_start();
    for (int i = 0; i < W + 1; i++) begin
      load_word(32'h100 + 32'(i), 1'b0, (i == W), (i == W) ? 0 : i);
      if (i == W - 2) begin
        n_chk++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_early got %b exp 0", overflow); end
      end
      if (i == W - 1) begin
        n_chk++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set got %b exp 1", overflow); end
      end
    end
    load_word(32'hB1, 1'b1, 1'b1, 1);
    hif.in_valid = 1'b0; hif.in_last = 1'b0;
    n_chk++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %b exp 1", overflow); end
  endtask

  // Entered on the sample right after the final load transfer.
  task automatic test_run_window(input bit pulse_start);
    int hi = 0;
    int lo = 0;
    while (core_rst === 1'b1 && hi < 50) begin hi++; tick(); end
    while (core_rst === 1'b0 && lo < 100) begin
      if (pulse_start && lo == 5) start = 1'b1;
      lo++;
      tick();
      start = 1'b0;
    end
    n_chk++; if (hi != RSTC) begin n_fail++; $display("FAIL run_rst_len got %0d exp %0d", hi, RSTC); end
    n_chk++; if (lo != RUNC) begin n_fail++; $display("FAIL run_len got %0d exp %0d", lo, RUNC); end
    n_chk++; if (dram_a2 !== 32'h0 || dram_we2 !== 4'h0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL dump_entry got a=%h we=%h busy=%b exp 0 0 1", dram_a2, dram_we2, busy); end
  endtask

  // Full dump with a stall on data word 3, or stop when data word stop_at is valid.
  task automatic test_dump(input int stop_at);
    int waits;
    logic [31:0] hold, expw, addr;
    for (int img = 0; img < 2; img++) begin
      for (int w = 0; w < W; w++) begin
        waits = 0;
        while (hif.out_valid !== 1'b1 && waits < 20) begin waits++; tick(); end
        if (img == 0 && w == stop_at) return;
        expw = (img == 0) ? exp_d[w] : exp_i[w];
        addr = (img == 0) ? dram_a2 : iram_a2;
        n_chk++; if (waits != RDL) begin n_fail++; $display("FAIL dump_lat img%0d w%0d got %0d exp %0d", img, w, waits, RDL); end
        n_chk++; if (hif.out_data !== expw) begin n_fail++; $display("FAIL dump_data img%0d w%0d got %h exp %h", img, w, hif.out_data, expw); end
        n_chk++; if (hif.out_last !== (w == W - 1)) begin n_fail++; $display("FAIL dump_last img%0d w%0d got %b exp %b", img, w, hif.out_last, (w == W - 1)); end
        n_chk++; if (addr !== 32'(w * 4)) begin n_fail++; $display("FAIL dump_addr img%0d w%0d got %h exp %h", img, w, addr, w * 4); end
        if (img == 0 && w == 3) begin
          hold = hif.out_data;
          for (int s = 0; s < 5; s++) begin
            tick();
            n_chk++; if (hif.out_valid !== 1'b1 || hif.out_data !== hold) begin
              n_fail++; $display("FAIL dump_stall c%0d got v=%b d=%h exp 1 %h", s, hif.out_valid, hif.out_data, hold); end
          end
        end
        hif.out_ready = 1'b1;
        tick();
        hif.out_ready = 1'b0;
        n_chk++; if (hif.out_valid !== 1'b0) begin n_fail++; $display("FAIL dump_accept img%0d w%0d got %b exp 0", img, w, hif.out_valid); end
      end
    end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL dump_end_busy got %b exp 0", busy); end
  endtask

  task automatic test_mid_reset();
    rst_n = 1'b0;
    #1;
    n_chk++; if (busy !== 1'b0 || core_rst !== 1'b1 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL mid_rst_status got busy=%b crst=%b ovf=%b exp 0 1 0", busy, core_rst, overflow); end
    n_chk++; if (hif.out_valid !== 1'b0 || hif.out_last !== 1'b0 || hif.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL mid_rst_hs got ov=%b ol=%b ir=%b exp 0 0 0", hif.out_valid, hif.out_last, hif.in_ready); end
    n_chk++; if (dram_a2 !== 32'h0 || iram_a2 !== 32'h0 || dram_we2 !== 4'h0 || iram_we2 !== 4'h0) begin
      n_fail++; $display("FAIL mid_rst_ram got da=%h ia=%h exp 0 0", dram_a2, iram_a2); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    test_start();
    load_word(32'h55, 1'b0, 1'b0, 0);
    load_word(32'h66, 1'b1, 1'b0, 1);
    load_word(32'hC0, 1'b1, 1'b1, 0);
    hif.in_valid = 1'b0; hif.in_last = 1'b0;
    n_chk++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rerun_overflow got %b exp 0", overflow); end
  endtask

  initial begin
    hif.in_valid = 1'b0; hif.in_data = '0; hif.in_last = 1'b0; hif.out_ready = 1'b0;
    test_reset();
    test_basic_load();
    test_run_window(1'b0);
    test_dump(-1);
    test_overflow();
    test_run_window(1'b0);
    test_dump(4);
    test_mid_reset();
    test_back_to_back();
    test_run_window(1'b1);
    test_dump(-1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule
